// File: rtl/instr_mem_if.sv
// Instruction fetch bus: req/gnt handshake plus the in-order rvalid/rdata/err response.
// The requester drives req and addr. The responder drives everything else.
interface instr_mem_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, addr, input gnt, rvalid, rdata, err);
   modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the fetch bus.
// - Grants word fetches while the in-flight count is below MAX_OUTSTANDING.
// - Answers every grant, in grant order, exactly LATENCY cycles after it.
// - Flags addresses outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) with err and zero data.
// - The RAM is filled through a separate loader write port.
// Optional build macro: IMEM_STALL_INJECT_EN adds an LFSR that randomly withholds gnt.
module instr_mem_responder #(
   parameter int          MEM_WORDS       = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          LATENCY         = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   instr_mem_if.slave                           bus,
   input  logic                                 load_we_i,
   input  logic [31:0]                          load_addr_i,
   input  logic [31:0]                          load_wdata_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

   localparam int            AW      = $clog2(MEM_WORDS);
   localparam int            OW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

   logic [31:0]   r_mem [MEM_WORDS];
   logic [OW-1:0] r_outstanding;
   logic          r_rvalid;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_borrow;
   logic [31:0]   w_off;
   logic [31:0]   w_idx;
   logic          w_err;
   logic [31:0]   w_rd_data;
   logic          w_stall;
   logic          w_gnt;
   logic          w_src_valid;
   logic [31:0]   w_src_data;
   logic          w_src_err;

   // The subtraction borrow marks addresses below BASE_ADDR.
   // This avoids an unsigned compare that is constant when BASE_ADDR is 0.
   assign {w_borrow, w_off} = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
   assign w_idx     = w_off >> 2;
   assign w_err     = w_borrow | (w_idx >= 32'(MEM_WORDS));
   assign w_rd_data = w_err ? 32'h0 : r_mem[w_idx[AW-1:0]];

`ifdef IMEM_STALL_INJECT_EN
   logic [15:0] r_lfsr;

   // Free-running Fibonacci LFSR (taps 16,14,13,11). It stalls gnt when the low bits are 00.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_lfsr <= 16'hACE1;
      else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
   assign w_stall = 1'b0;
`endif

   // gnt is combinational. rstn gates it so nothing is accepted while reset is asserted.
   assign w_gnt = rstn & bus.req & (r_outstanding < MAX_CNT) & ~w_stall;

   // Loader write port. Indices beyond the RAM are dropped rather than aliased.
   // NOTE: the RAM array has no reset branch, so it can map onto block RAM; contents are
   // defined only by the loader.
   always_ff @(posedge clk) begin
      if (load_we_i && (load_addr_i < 32'(MEM_WORDS)))
         r_mem[load_addr_i[AW-1:0]] <= load_wdata_i;
   end

   // The delay pipeline carries {valid, data, err} for LATENCY-1 stages.
   // The output register below supplies the final stage.
   generate
      if (LATENCY == 1) begin : g_direct
         assign w_src_valid = w_gnt;
         assign w_src_data  = w_rd_data;
         assign w_src_err   = w_err;
      end else begin : g_pipe
         logic        r_pv [LATENCY-1];
         logic [31:0] r_pd [LATENCY-1];
         logic        r_pe [LATENCY-1];

         // Stage 0 samples the RAM at the grant edge. A same-edge loader write therefore
         // yields the old word. Later stages are a plain shift.
         // NOTE: every sequential block uses non-blocking (<=) assignments, so all stages
         // sample pre-edge values and the shift order inside the loop does not matter.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int k = 0; k < LATENCY - 1; k++) begin
                  r_pv[k] <= 1'b0;
                  r_pd[k] <= 32'h0;
                  r_pe[k] <= 1'b0;
               end
            end else begin
               r_pv[0] <= w_gnt;
               r_pd[0] <= w_rd_data;
               r_pe[0] <= w_err;
               for (int k = 1; k < LATENCY - 1; k++) begin
                  r_pv[k] <= r_pv[k-1];
                  r_pd[k] <= r_pd[k-1];
                  r_pe[k] <= r_pe[k-1];
               end
            end
         end

         assign w_src_valid = r_pv[LATENCY-2];
         assign w_src_data  = r_pd[LATENCY-2];
         assign w_src_err   = r_pe[LATENCY-2];
      end
   endgenerate

   // The response register keeps the last rdata/err while rvalid is low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_src_valid;
         if (w_src_valid) begin
            r_rdata <= w_src_data;
            r_err   <= w_src_err;
         end
      end
   end

   // In-flight count. A request stops counting at the edge that raises its rvalid.
   // That frees its slot during the response cycle, so MAX_OUTSTANDING == LATENCY
   // sustains one grant per cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_outstanding <= '0;
      end else begin
         case ({w_gnt, w_src_valid})
            2'b10:   r_outstanding <= r_outstanding + OW'(1);
            2'b01:   r_outstanding <= r_outstanding - OW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.rvalid    = r_rvalid;
   assign bus.rdata     = r_rdata;
   assign bus.err       = r_err;
   assign outstanding_o = r_outstanding;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder.
// - u_dut uses the default parameters (LATENCY=2, MAX_OUTSTANDING=2).
// - u_dut_thr (LATENCY=3, MAX_OUTSTANDING=1) exercises grant throttling.
// Inputs change 1ns after the rising edge. Outputs are sampled on the falling edge.
module tb_instr_mem_responder;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   instr_mem_if bus ();
   instr_mem_if bus_t ();

   logic        load_we, load_we_t;
   logic [31:0] load_addr, load_wdata, load_addr_t, load_wdata_t;
   logic [1:0]  outst;
   logic        outst_t;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_mem [8];

   instr_mem_responder u_dut (
      .clk           (clk),
      .rstn          (rstn),
      .bus           (bus.slave),
      .load_we_i     (load_we),
      .load_addr_i   (load_addr),
      .load_wdata_i  (load_wdata),
      .outstanding_o (outst)
   );

   instr_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(1)) u_dut_thr (
      .clk           (clk),
      .rstn          (rstn),
      .bus           (bus_t.slave),
      .load_we_i     (load_we_t),
      .load_addr_i   (load_addr_t),
      .load_wdata_i  (load_wdata_t),
      .outstanding_o (outst_t)
   );

   task automatic cyc_begin;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic load_word(input int idx, input logic [31:0] d);
      cyc_begin;
      load_we = 1'b1; load_addr = 32'(idx); load_wdata = d;
      @(posedge clk);
      #1;
      load_we = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      bus.req = 1'b1; bus.addr = 32'h0;
      repeat (2) @(negedge clk);
      checks++; if (bus.gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt); end
      checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      checks++; if (outst !== 2'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outst); end
      bus.req = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic load_all;
      for (int i = 0; i < 8; i++) begin
         exp_mem[i] = (i == 0) ? 32'h0000_0013 : (32'hA5A5_0000 | 32'(i));
         load_word(i, exp_mem[i]);
      end
      cyc_begin;
      load_we_t = 1'b1; load_addr_t = 32'h0; load_wdata_t = 32'hCAFE_0001;
      @(posedge clk);
      #1;
      load_we_t = 1'b0;
   endtask

   task automatic test_basic;
      cyc_begin; bus.req = 1'b1; bus.addr = 32'h0; sample;
      checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL basic_gnt got=%b exp=1", bus.gnt); end
      cyc_begin; bus.req = 1'b0; sample;
      checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL basic_early_rvalid got=%b exp=0", bus.rvalid); end
      checks++; if (outst !== 2'd1) begin failures++; $display("FAIL basic_outstanding got=%0d exp=1", outst); end
      cyc_begin; sample;
      checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL basic_rvalid got=%b exp=1", bus.rvalid); end
      checks++; if (bus.rdata !== 32'h0000_0013) begin failures++; $display("FAIL basic_rdata got=%h exp=00000013", bus.rdata); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus.err); end
      checks++; if (outst !== 2'd0) begin failures++; $display("FAIL basic_outstanding_done got=%0d exp=0", outst); end
   endtask

   task automatic test_back_to_back;
      for (int n = 0; n < 12; n++) begin
         cyc_begin;
         bus.req = (n < 8); bus.addr = 32'(4 * n);
         sample;
         if (n < 8) begin
            checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt n=%0d got=%b exp=1", n, bus.gnt); end
         end
         if (n >= 2 && n < 10) begin
            checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp_mem[n-2])
               begin failures++; $display("FAIL b2b_resp n=%0d got=%b/%h exp=1/%h", n, bus.rvalid, bus.rdata, exp_mem[n-2]); end
         end
         if (n == 10) begin
            checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL b2b_tail_rvalid got=%b exp=0", bus.rvalid); end
         end
      end
   endtask

   task automatic test_throttle;
      for (int n = 0; n < 9; n++) begin
         cyc_begin;
         bus_t.req = 1'b1; bus_t.addr = 32'h0;
         sample;
         checks++; if (bus_t.gnt !== (n % 3 == 0))
            begin failures++; $display("FAIL thr_gnt n=%0d got=%b exp=%b", n, bus_t.gnt, (n % 3 == 0)); end
         checks++; if (outst_t !== (n % 3 != 0))
            begin failures++; $display("FAIL thr_outstanding n=%0d got=%b exp=%b", n, outst_t, (n % 3 != 0)); end
         if (n > 0 && n % 3 == 0) begin
            checks++; if (bus_t.rvalid !== 1'b1 || bus_t.rdata !== 32'hCAFE_0001)
               begin failures++; $display("FAIL thr_resp n=%0d got=%b/%h exp=1/cafe0001", n, bus_t.rvalid, bus_t.rdata); end
         end
      end
      bus_t.req = 1'b0;
      repeat (4) cyc_begin;
   endtask

   task automatic test_out_of_range;
      logic [31:0] addrs [3];
      addrs[0] = 32'd4096; addrs[1] = 32'd8; addrs[2] = 32'hFFFF_FFFC;
      for (int n = 0; n < 6; n++) begin
         cyc_begin;
         bus.req = (n < 3); bus.addr = (n < 3) ? addrs[n] : 32'h0;
         sample;
         if (n < 3) begin
            checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL oor_gnt n=%0d got=%b exp=1", n, bus.gnt); end
         end
         if (n == 2 || n == 4) begin
            checks++; if (bus.rvalid !== 1'b1 || bus.err !== 1'b1 || bus.rdata !== 32'h0)
               begin failures++; $display("FAIL oor_err n=%0d got=%b/%b/%h exp=1/1/0", n, bus.rvalid, bus.err, bus.rdata); end
         end
         if (n == 3) begin
            checks++; if (bus.rvalid !== 1'b1 || bus.err !== 1'b0 || bus.rdata !== exp_mem[2])
               begin failures++; $display("FAIL oor_next n=%0d got=%b/%b/%h exp=1/0/%h", n, bus.rvalid, bus.err, bus.rdata, exp_mem[2]); end
         end
         if (n == 5) begin
            checks++; if (bus.rvalid !== 1'b0 || bus.err !== 1'b1 || bus.rdata !== 32'h0)
               begin failures++; $display("FAIL oor_hold got=%b/%b/%h exp=0/1/0", bus.rvalid, bus.err, bus.rdata); end
         end
      end
   endtask

   task automatic test_load_collision;
      logic [31:0] old5;
      old5 = exp_mem[5];
      for (int n = 0; n < 5; n++) begin
         cyc_begin;
         bus.req  = (n < 3);
         bus.addr = (n == 2) ? 32'd12 : 32'd20;
         load_we  = (n < 2);
         load_addr  = (n == 0) ? 32'd5 : 32'd1027;
         load_wdata = (n == 0) ? 32'h0000_DEAD : 32'hBAD0_0BAD;
         sample;
         if (n == 2) begin
            checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== old5)
               begin failures++; $display("FAIL coll_old got=%b/%h exp=1/%h", bus.rvalid, bus.rdata, old5); end
         end
         if (n == 3) begin
            checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0000_DEAD)
               begin failures++; $display("FAIL coll_new got=%b/%h exp=1/0000dead", bus.rvalid, bus.rdata); end
         end
         if (n == 4) begin
            checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp_mem[3])
               begin failures++; $display("FAIL coll_oob_write got=%b/%h exp=1/%h", bus.rvalid, bus.rdata, exp_mem[3]); end
         end
      end
      load_we = 1'b0;
      exp_mem[5] = 32'h0000_DEAD;
   endtask

   task automatic test_reset_inflight;
      for (int n = 0; n < 2; n++) begin
         cyc_begin; bus.req = 1'b1; bus.addr = 32'(4 * n);
      end
      cyc_begin; rstn = 1'b0; sample;
      checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rst_fly_rvalid got=%b exp=0", bus.rvalid); end
      checks++; if (outst !== 2'd0) begin failures++; $display("FAIL rst_fly_outstanding got=%0d exp=0", outst); end
      checks++; if (bus.gnt !== 1'b0) begin failures++; $display("FAIL rst_fly_gnt got=%b exp=0", bus.gnt); end
      bus.req = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int n = 0; n < 4; n++) begin
         sample;
         checks++; if (bus.rvalid !== 1'b0 || outst !== 2'd0)
            begin failures++; $display("FAIL rst_fly_stale n=%0d got=%b/%0d exp=0/0", n, bus.rvalid, outst); end
      end
   endtask

   task automatic test_scoreboard;
      int          due_q [$];
      logic [31:0] dat_q [$];
      int          idx;
      for (int n = 0; n < 60; n++) begin
         cyc_begin;
         idx = $urandom_range(0, 7);
         bus.req  = (n < 48) && ($urandom_range(0, 3) != 0);
         bus.addr = 32'(4 * idx);
         sample;
         if (bus.rvalid) begin
            checks++;
            if (due_q.size() == 0) begin
               failures++; $display("FAIL sb_unexpected_rvalid n=%0d got=1 exp=0", n);
            end else begin
               if (due_q[0] != n || bus.rdata !== dat_q[0] || bus.err !== 1'b0) begin
                  failures++;
                  $display("FAIL sb_resp n=%0d got=%h/%b exp=%h/0 due=%0d", n, bus.rdata, bus.err, dat_q[0], due_q[0]);
               end
               void'(due_q.pop_front()); void'(dat_q.pop_front());
            end
         end else if (due_q.size() != 0 && due_q[0] == n) begin
            checks++; failures++;
            $display("FAIL sb_missing_rvalid n=%0d got=0 exp=1", n);
            void'(due_q.pop_front()); void'(dat_q.pop_front());
         end
         checks++; if (int'(outst) != due_q.size())
            begin failures++; $display("FAIL sb_outstanding n=%0d got=%0d exp=%0d", n, outst, due_q.size()); end
         if (bus.gnt === 1'b1) begin
            due_q.push_back(n + 2);
            dat_q.push_back(exp_mem[idx]);
         end
      end
      checks++; if (due_q.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", due_q.size()); end
   endtask

   initial begin
      bus.req = 1'b0; bus.addr = 32'h0;
      bus_t.req = 1'b0; bus_t.addr = 32'h0;
      load_we = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
      load_we_t = 1'b0; load_addr_t = 32'h0; load_wdata_t = 32'h0;
      test_reset;
      load_all;
`ifndef IMEM_STALL_INJECT_EN
      test_basic;
      test_back_to_back;
      test_throttle;
      test_out_of_range;
      test_load_collision;
      test_reset_inflight;
`endif
      test_scoreboard;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
